sample_ring_ctrl: RTL and testbench
===================================

# sample_ring_ctrl

Circular sample-buffer controller that sits directly upstream of the single-port 8192×16 sample RAM (RAM_8192 on FPGA, RAM_16B_8192_AR4_LP on ASIC). It writes a continuous stream of incoming samples into the RAM as a ring. It also serves "N samples ago" read requests from the downstream DFT stage over a request/ack handshake. The block owns all RAM port signals and arbitrates the single RAM port between writes and reads.

## Interface
- W_ADDR, 13, RAM address width; ring depth is 2^W_ADDR.
- W_DATA, 16, sample/RAM data width.

- clk  in  1  system clock; the RAM is clocked by the same clk.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  sample present this cycle; there is no backpressure and input is always accepted.
- in_data  in  W_DATA  sample value.
- flush  in  1  synchronous clear of the ring state.
- rd_req  in  1  read request; held until rd_ack.
- rd_offset  in  W_ADDR  age of the requested sample (0 = newest).
- rd_ack  out  1  request accepted this cycle (combinational).
- rd_valid  out  1  one-cycle pulse; rd_data/rd_err are valid.
- rd_data  out  W_DATA  returned sample (0 on error).
- rd_err  out  1  offset was ≥ fill_count at accept.
- fill_count  out  W_ADDR+1  number of valid samples; saturates at 2^W_ADDR.
- ram_address  out  W_ADDR  registered.
- ram_data  out  W_DATA  registered.
- ram_wren  out  1  registered; active-high write.
- ram_q  in  W_DATA  RAM read data, one cycle after the address edge.

## Operation
- State: wr_ptr (W_ADDR) is the next write address; fill_count is held in a register.
- Per-cycle priority: flush > in_valid write > read accept.
- **flush:**
  - Sets wr_ptr=0 and fill_count=0.
  - Drops any in_valid sample in the same cycle.
  - rd_ack=0 that cycle.
  - Reads already in flight complete normally.
- **Write (in_valid & ~flush):**
  - At the edge, registers ram_address=wr_ptr, ram_data=in_data, ram_wren=1.
  - wr_ptr increments and wraps from 2^W_ADDR−1 to 0.
  - fill_count increments, saturating at 2^W_ADDR.
- **Read accept:**
  - rd_ack = rd_req & ~in_valid & ~flush.
  - On accept, tag err = (rd_offset ≥ fill_count).
  - If not err: ram_address = wr_ptr − 1 − rd_offset (mod 2^W_ADDR) and ram_wren=0.
  - If err: no RAM address change is required and ram_wren=0.
- The offset is interpreted against the wr_ptr and fill_count at the accept edge. A read stalled by a write is re-evaluated against the new newest sample.
- Reads are pipelined:
  - One accept per cycle is allowed.
  - Results return strictly in accept order.
  - Pipeline stages: s1 (address registered), s2 (ram_q captured into rd_data).
- ram_wren is 0 in any cycle with no write.

## Timing
- Reset (rst=0, asynchronous): all outputs go to 0 immediately and remain 0 while reset is held.
  - This covers rd_ack, rd_valid, rd_data, rd_err, fill_count, ram_address, ram_data and ram_wren.
  - wr_ptr=0 and the pipeline is emptied.
- Reset mid-read: in-flight reads are discarded; rd_valid does not pulse after release.
- Write latency:
  - The RAM signals are driven from the edge after in_valid.
  - The RAM commits data on the following edge.
  - fill_count updates at the first edge.
- Read latency:
  - Accept at edge E0.
  - ram_address is valid after E0.
  - The RAM samples it at E1.
  - ram_q is captured at E2.
  - rd_valid=1 and rd_data/rd_err are valid for the cycle following E2, a fixed 2-edge latency.
- Err reads use the same 2-edge latency, with rd_data=0.
- A write in the cycle right after a read accept cannot corrupt that read, because ram_address for the write is only driven after the read address edge.
- fill_count = 2^W_ADDR means the ring is full. Further writes overwrite the oldest sample, and the count stays saturated.
- rd_offset = 2^W_ADDR−1 is legal only when the ring is full.

## Test plan
1. **Reset behaviour.** Assert rst=0, release, then rd_req with offset 0.
   - All outputs are 0 during reset.
   - rd_ack=1 on the request.
   - rd_valid pulses 2 edges later with rd_err=1 and rd_data=0.
2. **Basic write/read.** Write 0x8114, 0x2677, 0x1A1A, then read offsets 0, 2 and 3.
   - Returns 0x1A1A, then 0x8114, then rd_err=1.
   - fill_count=3.
   - Writes land at ram_address 0, 1, 2 with ram_wren=1.
3. **Collision.** Assert in_valid=1 (0x5555) and rd_req with offset 0 in the same cycle.
   - rd_ack=0 and the write goes to address 3.
   - Next cycle rd_ack=1, returning 0x5555.
4. **Wrap-around.** Write 8197 samples with value equal to the index.
   - fill_count=8192.
   - Last write at address 4.
   - Offset 0 returns 0x2004; offset 8191 returns 5.
5. **Back-to-back reads.** Issue offsets 0, 1, 2 on consecutive cycles.
   - rd_valid is high for 3 consecutive cycles with data in order.
6. **Flush, then reset mid-read.**
   - Flush while in_valid: fill_count=0, the sample is dropped, and the next write goes to address 0.
   - Assert rst 1 edge after a read accept: rd_valid never asserts.

Source files
------------

// File: rtl/sample_ring_ctrl_if.sv
// Bundle of the sample stream, the read request/ack port and the single-port RAM bus of sample_ring_ctrl.
// The controller takes the slave view; the source/consumer/RAM side takes the master view.
interface sample_ring_ctrl_if #(
    parameter int W_ADDR = 13,
    parameter int W_DATA = 16
);
    logic              in_valid;
    logic [W_DATA-1:0] in_data;
    logic              flush;
    logic              rd_req;
    logic [W_ADDR-1:0] rd_offset;
    logic              rd_ack;
    logic              rd_valid;
    logic [W_DATA-1:0] rd_data;
    logic              rd_err;
    logic [W_ADDR:0]   fill_count;
    logic [W_ADDR-1:0] ram_address;
    logic [W_DATA-1:0] ram_data;
    logic              ram_wren;
    logic [W_DATA-1:0] ram_q;

    modport slave (
        input  in_valid, in_data, flush, rd_req, rd_offset, ram_q,
        output rd_ack, rd_valid, rd_data, rd_err, fill_count,
               ram_address, ram_data, ram_wren
    );

    modport master (
        output in_valid, in_data, flush, rd_req, rd_offset, ram_q,
        input  rd_ack, rd_valid, rd_data, rd_err, fill_count,
               ram_address, ram_data, ram_wren
    );
endinterface

// File: rtl/sample_ring_ctrl.sv
// Ring-buffer controller for a single-port sample RAM: streams writes in as a ring and
// serves "N samples ago" reads with a fixed two-edge latency, writes taking priority.
module sample_ring_ctrl #(
    parameter int W_ADDR = 13,
    parameter int W_DATA = 16
) (
    input  logic                clk,
    input  logic                rst,
    sample_ring_ctrl_if.slave   bus
);
    localparam logic [W_ADDR:0]   DEPTH   = {1'b1, {W_ADDR{1'b0}}};
    localparam logic [W_ADDR-1:0] ADDR_1  = {{(W_ADDR-1){1'b0}}, 1'b1};

    logic [W_ADDR-1:0] wr_ptr_r;
    logic [W_ADDR:0]   fill_r;
    logic [W_ADDR-1:0] ram_address_r;
    logic [W_DATA-1:0] ram_data_r;
    logic              ram_wren_r;
    logic              s1_valid_r;
    logic              s1_err_r;
    logic              s2_valid_r;
    logic              s2_err_r;
    logic              rd_valid_r;
    logic              rd_err_r;
    logic [W_DATA-1:0] rd_data_r;

    logic              rd_ack_s;
    logic              rd_err_s;
    logic [W_ADDR-1:0] rd_addr_s;

    // Accept decision and address of the requested sample against the current ring state.
    always_comb begin
        rd_ack_s  = 1'b0;
        rd_err_s  = 1'b0;
        rd_addr_s = {W_ADDR{1'b0}};
        if (rst && bus.rd_req && !bus.in_valid && !bus.flush) begin
            rd_ack_s = 1'b1;
        end else begin
            rd_ack_s = 1'b0;
        end
        rd_err_s  = ({1'b0, bus.rd_offset} >= fill_r);
        rd_addr_s = wr_ptr_r - ADDR_1 - bus.rd_offset;
    end

    // Ring state and RAM port arbitration: flush beats write, write beats read accept.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r      <= {W_ADDR{1'b0}};
            fill_r        <= {(W_ADDR+1){1'b0}};
            ram_address_r <= {W_ADDR{1'b0}};
            ram_data_r    <= {W_DATA{1'b0}};
            ram_wren_r    <= 1'b0;
            s1_valid_r    <= 1'b0;
            s1_err_r      <= 1'b0;
        end else begin
            ram_wren_r <= 1'b0;
            s1_valid_r <= 1'b0;
            s1_err_r   <= 1'b0;
            if (bus.flush) begin
                wr_ptr_r <= {W_ADDR{1'b0}};
                fill_r   <= {(W_ADDR+1){1'b0}};
            end else if (bus.in_valid) begin
                ram_address_r <= wr_ptr_r;
                ram_data_r    <= bus.in_data;
                ram_wren_r    <= 1'b1;
                wr_ptr_r      <= wr_ptr_r + ADDR_1;
                if (fill_r != DEPTH) begin
                    fill_r <= fill_r + {{W_ADDR{1'b0}}, 1'b1};
                end else begin
                    fill_r <= fill_r;
                end
            end else if (rd_ack_s) begin
                s1_valid_r <= 1'b1;
                s1_err_r   <= rd_err_s;
                // An out-of-range read never touches the RAM address.
                if (!rd_err_s) begin
                    ram_address_r <= rd_addr_s;
                end else begin
                    ram_address_r <= ram_address_r;
                end
            end else begin
                ram_address_r <= ram_address_r;
            end
        end
    end

    // Read pipeline: s1 address registered, s2 RAM sampling, then ram_q captured as the result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid_r <= 1'b0;
            s2_err_r   <= 1'b0;
            rd_valid_r <= 1'b0;
            rd_err_r   <= 1'b0;
            rd_data_r  <= {W_DATA{1'b0}};
        end else begin
            s2_valid_r <= s1_valid_r;
            s2_err_r   <= s1_err_r;
            rd_valid_r <= s2_valid_r;
            rd_err_r   <= s2_valid_r & s2_err_r;
            rd_data_r  <= (s2_valid_r && !s2_err_r) ? bus.ram_q : {W_DATA{1'b0}};
        end
    end

    assign bus.rd_ack      = rd_ack_s;
    assign bus.rd_valid    = rd_valid_r;
    assign bus.rd_data     = rd_data_r;
    assign bus.rd_err      = rd_err_r;
    assign bus.fill_count  = fill_r;
    assign bus.ram_address = ram_address_r;
    assign bus.ram_data    = ram_data_r;
    assign bus.ram_wren    = ram_wren_r;
endmodule

// File: tb/tb_sample_ring_ctrl.sv
// Directed bench for sample_ring_ctrl with a behavioural 8192x16 registered-read RAM.
module tb_sample_ring_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    sample_ring_ctrl_if #(.W_ADDR(13), .W_DATA(16)) bus ();

    sample_ring_ctrl #(.W_ADDR(13), .W_DATA(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:8191];

    // RAM model: write commits at the edge, read data is the pre-write contents one edge later.
    always @(posedge clk) begin
        if (bus.ram_wren) mem[bus.ram_address] <= bus.ram_data;
        bus.ram_q <= mem[bus.ram_address];
    end

    typedef struct {
        logic        iv;
        logic [15:0] id;
        logic        fl;
        logic        rq;
        logic [12:0] off;
        logic        ack;
        logic        vld;
        logic [15:0] dat;
        logic        err;
        logic [13:0] fill;
        logic        wren;
        logic [12:0] addr;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t mk(input logic iv, input logic [15:0] id, input logic fl,
                                input logic rq, input logic [12:0] off, input logic ack,
                                input logic vld, input logic [15:0] dat, input logic err,
                                input logic [13:0] fill, input logic wren, input logic [12:0] addr);
        vec_t v;
        v.iv = iv; v.id = id; v.fl = fl; v.rq = rq; v.off = off; v.ack = ack;
        v.vld = vld; v.dat = dat; v.err = err; v.fill = fill; v.wren = wren; v.addr = addr;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [15:0] id, input logic fl,
                         input logic rq, input logic [12:0] off);
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.flush     = fl;
        bus.rd_req    = rq;
        bus.rd_offset = off;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " rd_ack"},      {31'd0, bus.rd_ack},      32'd0);
        chk({tag, " rd_valid"},    {31'd0, bus.rd_valid},    32'd0);
        chk({tag, " rd_data"},     {16'd0, bus.rd_data},     32'd0);
        chk({tag, " rd_err"},      {31'd0, bus.rd_err},      32'd0);
        chk({tag, " fill_count"},  {18'd0, bus.fill_count},  32'd0);
        chk({tag, " ram_address"}, {19'd0, bus.ram_address}, 32'd0);
        chk({tag, " ram_data"},    {16'd0, bus.ram_data},    32'd0);
        chk({tag, " ram_wren"},    {31'd0, bus.ram_wren},    32'd0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 16'd0;
        bus.ram_q = 16'd0;

        //                iv  id        fl    rq    off      ack   vld   dat       err   fill    wren  addr
        tbl[0]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd0, 1'b0, 13'd0);
        tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd0, 1'b0, 13'd0);
        tbl[2]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 14'd0, 1'b0, 13'd0);
        tbl[3]  = mk(1'b1, 16'h8114, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd1, 1'b1, 13'd0);
        tbl[4]  = mk(1'b1, 16'h2677, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd2, 1'b1, 13'd1);
        tbl[5]  = mk(1'b1, 16'h1A1A, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd3, 1'b1, 13'd2);
        tbl[6]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd3, 1'b0, 13'd2);
        tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd2, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd3, 1'b0, 13'd0);
        tbl[8]  = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd3, 1'b1, 1'b1, 16'h1A1A, 1'b0, 14'd3, 1'b0, 13'd0);
        tbl[9]  = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 16'h8114, 1'b0, 14'd3, 1'b0, 13'd0);
        tbl[10] = mk(1'b1, 16'h5555, 1'b0, 1'b1, 13'd0, 1'b0, 1'b1, 16'h0000, 1'b1, 14'd4, 1'b1, 13'd3);
        tbl[11] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd4, 1'b0, 13'd3);
        tbl[12] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd1, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd4, 1'b0, 13'd2);
        tbl[13] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd2, 1'b1, 1'b1, 16'h5555, 1'b0, 14'd4, 1'b0, 13'd1);
        tbl[14] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd3, 1'b1, 1'b1, 16'h1A1A, 1'b0, 14'd4, 1'b0, 13'd0);
        tbl[15] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 16'h2677, 1'b0, 14'd4, 1'b0, 13'd0);
        tbl[16] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 16'h8114, 1'b0, 14'd4, 1'b0, 13'd0);
        tbl[17] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd4, 1'b0, 13'd0);
        tbl[18] = mk(1'b1, 16'h7777, 1'b1, 1'b1, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd0, 1'b0, 13'd0);
        tbl[19] = mk(1'b1, 16'h1234, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd1, 1'b1, 13'd0);
        tbl[20] = mk(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 14'd1, 1'b0, 13'd0);
        tbl[21] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b0, 16'h0000, 1'b0, 14'd1, 1'b0, 13'd0);
        tbl[22] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0, 1'b0, 1'b1, 16'h1234, 1'b0, 14'd1, 1'b0, 13'd0);

        // Reset held with active stimulus: everything stays at zero.
        drive(1'b1, 16'hFFFF, 1'b0, 1'b1, 13'd0);
        repeat (3) @(posedge clk);
        #2;
        chk_all_zero("reset");
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
        #1;
        rst = 1'b1;
        tick();

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].iv, tbl[i].id, tbl[i].fl, tbl[i].rq, tbl[i].off);
            #1;
            chk($sformatf("row%0d rd_ack", i), {31'd0, bus.rd_ack}, {31'd0, tbl[i].ack});
            tick();
            chk($sformatf("row%0d rd_valid", i), {31'd0, bus.rd_valid}, {31'd0, tbl[i].vld});
            chk($sformatf("row%0d rd_data", i), {16'd0, bus.rd_data}, {16'd0, tbl[i].dat});
            chk($sformatf("row%0d rd_err", i), {31'd0, bus.rd_err}, {31'd0, tbl[i].err});
            chk($sformatf("row%0d fill_count", i), {18'd0, bus.fill_count}, {18'd0, tbl[i].fill});
            chk($sformatf("row%0d ram_wren", i), {31'd0, bus.ram_wren}, {31'd0, tbl[i].wren});
            chk($sformatf("row%0d ram_address", i), {19'd0, bus.ram_address}, {19'd0, tbl[i].addr});
            if (tbl[i].wren) begin
                chk($sformatf("row%0d ram_data", i), {16'd0, bus.ram_data}, {16'd0, tbl[i].id});
            end
        end

        // Wrap-around: 8197 writes of the index after a flush.
        drive(1'b0, 16'h0000, 1'b1, 1'b0, 13'd0);
        tick();
        chk("wrap flush fill", {18'd0, bus.fill_count}, 32'd0);
        for (int i = 0; i < 8197; i++) begin
            drive(1'b1, 16'(i), 1'b0, 1'b0, 13'd0);
            tick();
            if (i == 8191 || i == 8192) begin
                chk($sformatf("wrap fill at %0d", i), {18'd0, bus.fill_count}, 32'd8192);
            end
        end
        chk("wrap last addr", {19'd0, bus.ram_address}, 32'd4);
        chk("wrap last data", {16'd0, bus.ram_data}, 32'h2004);
        chk("wrap last wren", {31'd0, bus.ram_wren}, 32'd1);
        chk("wrap fill sat", {18'd0, bus.fill_count}, 32'd8192);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0);
        #1;
        chk("wrap ack off0", {31'd0, bus.rd_ack}, 32'd1);
        tick();
        chk("wrap addr off0", {19'd0, bus.ram_address}, 32'd4);
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 13'd8191);
        #1;
        chk("wrap ack off8191", {31'd0, bus.rd_ack}, 32'd1);
        tick();
        chk("wrap addr off8191", {19'd0, bus.ram_address}, 32'd5);
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
        tick();
        chk("wrap off0 valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("wrap off0 data", {16'd0, bus.rd_data}, 32'h2004);
        chk("wrap off0 err", {31'd0, bus.rd_err}, 32'd0);
        tick();
        chk("wrap off8191 valid", {31'd0, bus.rd_valid}, 32'd1);
        chk("wrap off8191 data", {16'd0, bus.rd_data}, 32'd5);
        chk("wrap off8191 err", {31'd0, bus.rd_err}, 32'd0);
        tick();
        chk("wrap idle valid", {31'd0, bus.rd_valid}, 32'd0);

        // Reset one edge after a read accept discards the read.
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 13'd0);
        #1;
        chk("midrst ack", {31'd0, bus.rd_ack}, 32'd1);
        tick();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 13'd0);
        tick();
        #2;
        rst = 1'b0;
        #1;
        chk_all_zero("midrst");
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("midrst no valid %0d", i), {31'd0, bus.rd_valid}, 32'd0);
        end
        chk("midrst fill", {18'd0, bus.fill_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
